// File: rtl/uart_tx_arb.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_ARB_PRIO_EN to give requester 0 strict priority over a round-robin of the rest.
module uart_tx_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   busy,
    output logic [IDX_W-1:0]       gnt_id
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_CLR  = 3'd2,
        ST_BUSY = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   rr_ptr_s;
    logic [NUM_REQ-1:0] ack_s;
    logic               trmt_s;
    logic               busy_s;
    logic [7:0]         tx_data_s;
    logic [IDX_W-1:0]   gnt_id_s;
    logic               win_vld_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [IDX_W-1:0]   cand_s;
    logic [IDX_W-1:0]   floor_s;

    // Increment with explicit wrap; floor_idx is the index the pointer wraps back to.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                  input logic [IDX_W-1:0] floor_idx);
        if (int'(idx) >= NUM_REQ - 1) begin
            wrap_inc = floor_idx;
        end else begin
            wrap_inc = idx + IDX_W'(1'b1);
        end
    endfunction

    // Winner search: first asserted request at or above the start index, wrapping.
    always_comb begin
        win_vld_s = 1'b0;
        win_idx_s = '0;
`ifdef UART_ARB_PRIO_EN
        floor_s = IDX_W'(1'b1);
        if (rr_ptr_r == '0) begin
            cand_s = IDX_W'(1'b1);
        end else begin
            cand_s = rr_ptr_r;
        end
        if (req[0]) begin
            win_vld_s = 1'b1;
            win_idx_s = '0;
        end else begin
            for (int i = 0; i < NUM_REQ - 1; i++) begin
                if (!win_vld_s && req[cand_s]) begin
                    win_vld_s = 1'b1;
                    win_idx_s = cand_s;
                end else begin
                    win_vld_s = win_vld_s;
                end
                cand_s = wrap_inc(cand_s, floor_s);
            end
        end
`else
        floor_s = '0;
        cand_s  = rr_ptr_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld_s && req[cand_s]) begin
                win_vld_s = 1'b1;
                win_idx_s = cand_s;
            end else begin
                win_vld_s = win_vld_s;
            end
            cand_s = wrap_inc(cand_s, floor_s);
        end
`endif
    end

    // Next-state and next-output logic; every output is taken from a register.
    always_comb begin
        state_s   = state_r;
        rr_ptr_s  = rr_ptr_r;
        ack_s     = '0;
        tx_data_s = tx_data;
        gnt_id_s  = gnt_id;
        case (state_r)
            ST_IDLE: begin
                if (tx_done && win_vld_s) begin
                    state_s   = ST_SEND;
                    tx_data_s = req_data[{win_idx_s, 3'b000} +: 8];
                    gnt_id_s  = win_idx_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                state_s = ST_CLR;
            end
            ST_CLR: begin
                // A high tx_done here is left over from the previous byte.
                if (!tx_done) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_CLR;
                end
            end
            ST_BUSY: begin
                if (tx_done) begin
                    state_s       = ST_ACK;
                    ack_s[gnt_id] = 1'b1;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
`ifdef UART_ARB_PRIO_EN
                if (gnt_id != '0) begin
                    rr_ptr_s = wrap_inc(gnt_id, IDX_W'(1'b1));
                end else begin
                    rr_ptr_s = rr_ptr_r;
                end
`else
                rr_ptr_s = wrap_inc(gnt_id, '0);
`endif
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        trmt_s = (state_s == ST_SEND);
        busy_s = (state_s != ST_IDLE);
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
            ack      <= '0;
            trmt     <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            gnt_id   <= '0;
        end else begin
            state_r  <= state_s;
            rr_ptr_r <= rr_ptr_s;
            ack      <= ack_s;
            trmt     <= trmt_s;
            tx_data  <= tx_data_s;
            busy     <= busy_s;
            gnt_id   <= gnt_id_s;
        end
    end

endmodule
